mux_scan_serializer: RTL and testbench
======================================

// Module: mux_scan_serializer
//
// PURPOSE
//   Sequencer and capture stage for the 8:1 bit multiplexer (mux8_1).
//   - Drives the mux select through channels 0..NUM_CH-1 in order.
//   - Waits a programmable settle time on each channel, then samples the mux output y.
//   - Packs the NUM_CH samples into one word and hands it downstream on a valid/ready handshake.
//   - Supports single-shot and continuous scan modes.
//
// PARAMETERS
//   NUM_CH     8   channels scanned; power of two, 2..16
//   SEL_W      3   select width; must equal $clog2(NUM_CH)
//   SETTLE_CYC 1   idle cycles after each sel change before sampling; 0..15 (0 = sample immediately)
//
// PORTS
//   clk        in   1       single clock; all state on rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   start      in   1       begin a scan; sampled only in IDLE
//   cont       in   1       1 = restart automatically after each accepted word
//   y          in   1       mux output being sampled
//   sel        out  SEL_W   mux select
//   data_out   out  NUM_CH  captured word; bit k = y sampled while sel==k
//   valid      out  1       data_out holds a complete word
//   ready      in   1       downstream accepts the word when valid&&ready
//   busy       out  1       1 in every state except IDLE
//   start_ign  out  1       one-cycle pulse: start=1 arrived while not IDLE
//
// BEHAVIOUR
//   Reset (async assert; release synchronised to clk edge):
//   - state=IDLE; sel, data_out, shift reg and settle counter = 0.
//   - valid=0, busy=0, start_ign=0.
//
//   FSM states: IDLE, SETTLE, SAMPLE, HOLD.
//   - IDLE -> SETTLE on start=1, with sel=0 and cnt=0.
//     If SETTLE_CYC=0, IDLE -> SAMPLE directly.
//   - SETTLE: cnt increments each cycle. When cnt==SETTLE_CYC-1, go to SAMPLE.
//   - SAMPLE (one cycle): cap[sel] <= y.
//     - If sel==NUM_CH-1: data_out <= cap with bit NUM_CH-1 = y; valid <= 1; go to HOLD.
//     - Otherwise: sel <= sel+1; cnt <= 0; go to SETTLE (or SAMPLE if SETTLE_CYC=0).
//   - HOLD: data_out and valid held stable until valid&&ready.
//     On acceptance: valid <= 0 and sel <= 0.
//     Then go to SETTLE/SAMPLE if cont=1, else go to IDLE.
//
//   Latency and timing:
//   - sel is constant for SETTLE_CYC+1 cycles per channel.
//   - valid rises NUM_CH*(SETTLE_CYC+1) clocks after the edge that samples start (default: 16).
//   - Throughput in continuous mode with ready tied high: one word per NUM_CH*(SETTLE_CYC+1)+1 cycles.
//
//   Boundary conditions:
//   - sel never exceeds NUM_CH-1; the wrap from NUM_CH-1 to 0 happens only on acceptance.
//   - start while busy: ignored, start_ign=1 for that cycle, scan continues undisturbed.
//   - cont sampled only at acceptance; changing it mid-scan has no effect until then.
//   - ready=1 outside HOLD: no effect.
//   - ready=1 on the same edge valid rises: that word is accepted on the following edge, not earlier.
//   - rst_n low mid-scan or mid-HOLD: immediate return to reset values; partial word discarded.
//   - y changes during SETTLE: only the value present at the SAMPLE edge is captured.
//
// STRUCTURE
//   - mux_scan_pkg holds the state enum (IDLE, SETTLE, SAMPLE, HOLD) and the default NUM_CH/SEL_W constants.
//   - No sub-module required. The settle counter is 4 bits, in-line.
//   - The top-level bench instantiates mux8_1 with its sel and y wired to this block.
//
// TESTING
//   1. Reset: rst_n=0 mid-run -> sel=0, valid=0, busy=0, data_out=0 the same cycle (async).
//   2. Single shot: mux inputs i0..i7 = 0,1,0,0,0,1,1,0; start pulse; ready=1; cont=0
//      -> sel steps 0..7, each held 2 cycles; valid rises after 16 clocks; data_out=8'h62;
//      back to IDLE after acceptance.
//   3. Backpressure: ready=0 for 10 cycles after valid
//      -> data_out=8'h62 and valid remain stable; one accept edge clears valid.
//   4. Continuous: cont=1, ready=1, inputs changed to all-ones after the first word
//      -> first word 8'h62, second word 8'hFF, sel wraps 7->0 with no IDLE cycle.
//   5. Start while busy: start pulse at cycle 5 of a scan
//      -> start_ign=1 for one cycle; word and timing identical to scenario 2.
//   6. SETTLE_CYC=0 build: single shot -> sel advances every cycle; valid after 8 clocks; data correct.

Source files
------------

// File: rtl/mux_scan_serializer_pkg.sv
// mux_scan_pkg: shared types and default sizing for the mux scan serializer.
//   state_t     : scan FSM states
//   NUM_CH_DEF  : default channel count
//   SEL_W_DEF   : default select width ($clog2 of NUM_CH_DEF)
package mux_scan_pkg;

   localparam int NUM_CH_DEF = 8;
   localparam int SEL_W_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/mux_scan_serializer_if.sv
// mux_scan_serializer_if: control, mux and word handshake signals of the serializer.
//   start, cont : scan control (from controller)
//   y, sel      : sampled mux output / mux select
//   data_out, valid, ready : captured word handshake
//   busy, start_ign        : status
// master = controller/downstream side, slave = serializer side.
interface mux_scan_serializer_if
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int SEL_W  = SEL_W_DEF
);
   logic              start;
   logic              cont;
   logic              y;
   logic              ready;
   logic [SEL_W-1:0]  sel;
   logic [NUM_CH-1:0] data_out;
   logic              valid;
   logic              busy;
   logic              start_ign;

   modport master (
      output start, cont, y, ready,
      input  sel, data_out, valid, busy, start_ign
   );

   modport slave (
      input  start, cont, y, ready,
      output sel, data_out, valid, busy, start_ign
   );
endinterface

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer: steps a mux select through all channels, waits SETTLE_CYC
// cycles on each, samples y, and presents the packed word on valid/ready.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport (start, cont, y, ready in; sel, data_out, valid, busy, start_ign out)
module mux_scan_serializer
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH     = NUM_CH_DEF,
   parameter int SEL_W      = SEL_W_DEF,
   parameter int SETTLE_CYC = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   mux_scan_serializer_if.slave bus
);

   // With no settle time every channel goes straight to its sample cycle.
   localparam state_t           CH_ENTRY = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
   localparam logic [3:0]       CNT_LAST = 4'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CH - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic [NUM_CH-1:0] cap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         cap           <= '0;
         bus.sel       <= '0;
         bus.data_out  <= '0;
         bus.valid     <= 1'b0;
         bus.busy      <= 1'b0;
         bus.start_ign <= 1'b0;
      end else begin
         bus.start_ign <= bus.start && (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= CH_ENTRY;
                  bus.sel  <= '0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
               end
            end
            SETTLE: begin
               cnt <= cnt + 4'd1;
               if (cnt == CNT_LAST) state <= SAMPLE;
            end
            SAMPLE: begin
               cap[bus.sel] <= bus.y;
               if (bus.sel == SEL_LAST) begin
                  // Last channel: its bit comes straight from y, cap is not yet updated.
                  bus.data_out <= {bus.y, cap[NUM_CH-2:0]};
                  bus.valid    <= 1'b1;
                  state        <= HOLD;
               end else begin
                  bus.sel <= bus.sel + SEL_W'(1);
                  cnt     <= '0;
                  state   <= CH_ENTRY;
               end
            end
            HOLD: begin
               // valid is always 1 here, so ready alone marks acceptance.
               if (bus.ready) begin
                  bus.valid <= 1'b0;
                  bus.sel   <= '0;
                  cnt       <= '0;
                  if (bus.cont) begin
                     state <= CH_ENTRY;
                  end else begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer: directed, table-driven bench for two builds
// (SETTLE_CYC=1 and SETTLE_CYC=0), each fed by a behavioural 8:1 mux.
module tb_mux_scan_serializer;
   import mux_scan_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus, steered to one build by dsel.
   logic       dsel = 1'b0;
   logic       start = 1'b0, cont = 1'b0, ready = 1'b0;
   logic [7:0] min0 = '0, min1 = '0;

   mux_scan_serializer_if #(.NUM_CH(8), .SEL_W(3)) bus0 ();
   mux_scan_serializer_if #(.NUM_CH(8), .SEL_W(3)) bus1 ();

   assign bus0.start = start & ~dsel;
   assign bus0.cont  = cont  & ~dsel;
   assign bus0.ready = ready & ~dsel;
   assign bus0.y     = min0[bus0.sel];   // 8:1 mux model
   assign bus1.start = start & dsel;
   assign bus1.cont  = cont  & dsel;
   assign bus1.ready = ready & dsel;
   assign bus1.y     = min1[bus1.sel];

   mux_scan_serializer #(.NUM_CH(8), .SEL_W(3), .SETTLE_CYC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mux_scan_serializer #(.NUM_CH(8), .SEL_W(3), .SETTLE_CYC(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] g_sel();   return dsel ? bus1.sel : bus0.sel; endfunction
   function automatic logic [7:0] g_data();  return dsel ? bus1.data_out : bus0.data_out; endfunction
   function automatic logic       g_valid(); return dsel ? bus1.valid : bus0.valid; endfunction
   function automatic logic       g_busy();  return dsel ? bus1.busy : bus0.busy; endfunction
   function automatic logic       g_ign();   return dsel ? bus1.start_ign : bus0.start_ign; endfunction

   // One single-shot scan. ign_at>=0 injects a start pulse after that many edges;
   // bp>0 holds ready low for bp cycles after valid rises.
   task automatic run_scan(input string nm, input logic d, input logic [7:0] pat,
                           input logic [7:0] expw, input int ign_at, input int bp);
      int hold, lat, k, serr, stab;
      dsel = d;
      hold = d ? 1 : 2;
      lat  = 8 * hold;
      serr = 0;
      stab = 0;
      if (d) min1 = pat; else min0 = pat;
      cont  = 1'b0;
      ready = (bp == 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_busy"}, 32'(g_busy()), 32'd1);
      k = 0;
      while (!g_valid() && k < 100) begin
         if (g_sel() != 3'(k / hold)) serr++;
         if (k == ign_at) start = 1'b1;
         tick();
         k++;
         if (ign_at >= 0 && k == ign_at + 1) begin
            start = 1'b0;
            chk({nm, "_ign_pulse"}, 32'(g_ign()), 32'd1);
         end
         if (ign_at >= 0 && k == ign_at + 2) chk({nm, "_ign_clear"}, 32'(g_ign()), 32'd0);
      end
      chk({nm, "_sel_seq_errs"}, 32'(serr), 32'd0);
      chk({nm, "_latency"}, 32'(k), 32'(lat));
      chk({nm, "_word"}, 32'(g_data()), 32'(expw));
      chk({nm, "_sel_at_valid"}, 32'(g_sel()), 32'd7);
      if (bp > 0) begin
         repeat (bp) begin
            tick();
            if (!g_valid() || g_data() != expw || g_sel() != 3'd7) stab++;
         end
         chk({nm, "_bp_unstable"}, 32'(stab), 32'd0);
         ready = 1'b1;
      end
      tick();
      chk({nm, "_valid_clr"}, 32'(g_valid()), 32'd0);
      chk({nm, "_busy_clr"}, 32'(g_busy()), 32'd0);
      chk({nm, "_sel_wrap"}, 32'(g_sel()), 32'd0);
      ready = 1'b0;
   endtask

   typedef struct {
      string      nm;
      logic       d;
      logic [7:0] pat;
      logic [7:0] expw;
   } vec_t;

   initial begin
      vec_t vt[6];
      int   k;

      vt[0] = '{"s1_62", 1'b0, 8'b0110_0010, 8'h62};
      vt[1] = '{"s1_00", 1'b0, 8'b0000_0000, 8'h00};
      vt[2] = '{"s1_a5", 1'b0, 8'b1010_0101, 8'ha5};
      vt[3] = '{"s1_81", 1'b0, 8'b1000_0001, 8'h81};
      vt[4] = '{"s0_62", 1'b1, 8'b0110_0010, 8'h62};
      vt[5] = '{"s0_5c", 1'b1, 8'b0101_1100, 8'h5c};

      // Reset state
      #12;
      chk("rst_sel", 32'(bus0.sel), 32'd0);
      chk("rst_valid", 32'(bus0.valid), 32'd0);
      chk("rst_busy", 32'(bus0.busy), 32'd0);
      chk("rst_data", 32'(bus0.data_out), 32'd0);
      chk("rst_ign", 32'(bus0.start_ign), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Table: single shots on both builds, ready high throughout
      for (int i = 0; i < 6; i++) run_scan(vt[i].nm, vt[i].d, vt[i].pat, vt[i].expw, -1, 0);

      // Backpressure: 10 cycles of ready=0 after valid
      run_scan("bp", 1'b0, 8'h62, 8'h62, -1, 10);

      // Start while busy, injected after edge 5
      run_scan("ign", 1'b0, 8'h62, 8'h62, 5, 0);

      // Continuous: two back-to-back words, no IDLE between them
      dsel = 1'b0; min0 = 8'h62; cont = 1'b1; ready = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      k = 0;
      while (!bus0.valid && k < 100) begin tick(); k++; end
      chk("cont_lat1", 32'(k), 32'd16);
      chk("cont_word1", 32'(bus0.data_out), 32'h62);
      min0 = 8'hff;
      tick();
      chk("cont_acc_valid", 32'(bus0.valid), 32'd0);
      chk("cont_acc_busy", 32'(bus0.busy), 32'd1);
      chk("cont_acc_sel", 32'(bus0.sel), 32'd0);
      cont = 1'b0;   // only observed at the next acceptance
      k = 0;
      while (!bus0.valid && k < 100) begin tick(); k++; end
      chk("cont_lat2", 32'(k), 32'd16);
      chk("cont_word2", 32'(bus0.data_out), 32'hff);
      tick();
      chk("cont_end_busy", 32'(bus0.busy), 32'd0);
      ready = 1'b0;

      // Async reset mid-scan
      min0 = 8'h62;
      start = 1'b1; tick(); start = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_sel", 32'(bus0.sel), 32'd0);
      chk("rst_mid_busy", 32'(bus0.busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Async reset mid-HOLD discards the held word
      start = 1'b1; tick(); start = 1'b0;
      k = 0;
      while (!bus0.valid && k < 100) begin tick(); k++; end
      repeat (3) tick();
      chk("hold_word", 32'(bus0.data_out), 32'h62);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_hold_valid", 32'(bus0.valid), 32'd0);
      chk("rst_hold_data", 32'(bus0.data_out), 32'd0);
      chk("rst_hold_busy", 32'(bus0.busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
